picorv32_trace_capture: RTL

Trace capture buffer that consumes the 36-bit `trace_valid`/`trace_data` stream of the PicoRV32 demo system and records it into an on-chip circular buffer. Capture is stopped by a trigger: `trap` from the core, or a software stop. A programmable number of post-trigger entries is recorded before the buffer freezes. A classic Wishbone slave reads back the frozen history in oldest-first order. `done_o` is intended for wiring into a spare `irq_i` bit.

---
 rtl/picorv32_trace_pkg.sv | 31 +++
 rtl/trace_ram_sdp.sv | 25 ++
 rtl/picorv32_trace_capture.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_trace_pkg.sv
// Shared types and constants for the PicoRV32 trace capture buffer.
package picorv32_trace_pkg;

    localparam int unsigned TRACE_W = 36;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam logic [WB_AW-1:0] ADR_CTRL    = 3'd0;
    localparam logic [WB_AW-1:0] ADR_STATUS  = 3'd1;
    localparam logic [WB_AW-1:0] ADR_COUNT   = 3'd2;
    localparam logic [WB_AW-1:0] ADR_RD_IDX  = 3'd3;
    localparam logic [WB_AW-1:0] ADR_DATA_LO = 3'd4;
    localparam logic [WB_AW-1:0] ADR_DATA_HI = 3'd5;

    localparam int unsigned CTRL_ARM   = 0;
    localparam int unsigned CTRL_CLEAR = 1;
    localparam int unsigned CTRL_STOP  = 2;

    localparam int unsigned STAT_STATE_LSB = 0;
    localparam int unsigned STAT_STATE_MSB = 1;
    localparam int unsigned STAT_WRAPPED   = 2;
    localparam int unsigned STAT_TRIG_SRC  = 3;

endpackage

// File: rtl/trace_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
module trace_ram_sdp #(
    parameter int unsigned WIDTH      = 36,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/picorv32_trace_capture.sv
// Trigger-frozen circular trace buffer for the PicoRV32 trace port,
// read back oldest-first through a classic Wishbone slave.
module picorv32_trace_capture
    import picorv32_trace_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned POST_TRIG  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trace_valid_i,
    input  logic [TRACE_W-1:0] trace_data_i,
    input  logic               trap_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [WB_AW-1:0]   wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack_o,
    output logic               done_o
);

    localparam int unsigned DL = DEPTH_LOG2;
    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL      = CW'(2 ** DEPTH_LOG2);
    localparam logic [DL-1:0] POST_LOAD = DL'(POST_TRIG);

    trace_state_e     state_q, state_d;
    logic [DL-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [DL-1:0]    rd_idx_q, rd_idx_d;
    logic [DL-1:0]    post_cnt_q, post_cnt_d;
    logic             trig_stop_q, trig_stop_d;
    logic             ack_q, ack_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic             done_q, done_d;

    logic               ram_we;
    logic [DL-1:0]      ram_raddr;
    logic [TRACE_W-1:0] ram_rdata;

    logic             wb_req, wb_wr, ctrl_wr;
    logic             do_clear, do_arm, do_stop;
    logic             data_ok;
    logic [DL-1:0]    eff_idx, next_idx;
    logic [CW-1:0]    idx_sum;
    logic [WB_DW-1:0] status_w;
    logic             unused_wdat;

    assign unused_wdat = ^wb_dat_i;

    trace_ram_sdp #(
        .WIDTH      (TRACE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (trace_data_i),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Bus decode and logical-to-physical read index mapping
    always_comb begin
        wb_req   = wb_cyc_i & wb_stb_i & ~ack_q;
        wb_wr    = wb_req & wb_we_i;
        ctrl_wr  = wb_wr & (wb_adr_i == ADR_CTRL);
        do_clear = ctrl_wr & wb_dat_i[CTRL_CLEAR];
        do_arm   = ctrl_wr & wb_dat_i[CTRL_ARM] & ~do_clear;
        do_stop  = ctrl_wr & wb_dat_i[CTRL_STOP];

        eff_idx   = (count_q == '0) ? '0 : DL'(CW'(rd_idx_q) % count_q);
        ram_raddr = (wrapped_q ? wr_ptr_q : '0) + eff_idx;
        idx_sum   = CW'(eff_idx) + CW'(1);
        next_idx  = (idx_sum == count_q) ? '0 : DL'(idx_sum);
        data_ok   = (state_q != ST_IDLE) && (count_q != '0);

        status_w = '0;
        status_w[STAT_STATE_MSB:STAT_STATE_LSB] = state_q;
        status_w[STAT_WRAPPED]  = wrapped_q;
        status_w[STAT_TRIG_SRC] = trig_stop_q;
    end

    // Next-state, capture and register-access logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        rd_idx_d    = rd_idx_q;
        post_cnt_d  = post_cnt_q;
        trig_stop_d = trig_stop_q;
        ack_d       = wb_req;
        dat_d       = '0;
        ram_we      = 1'b0;

        unique case (state_q)
            ST_ARMED: begin
                ram_we = trace_valid_i;
                if (do_stop || trap_i) begin
                    trig_stop_d = do_stop;
                    if (POST_TRIG == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_POST;
                        post_cnt_d = POST_LOAD;
                    end
                end
            end
            ST_POST: begin
                ram_we = trace_valid_i;
                if (trace_valid_i) begin
                    post_cnt_d = post_cnt_q - DL'(1);
                    if (post_cnt_q == DL'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: ;
        endcase

        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + DL'(1);
            if (wr_ptr_q == '1) begin
                wrapped_d = 1'b1;
            end
            if (count_q != FULL) begin
                count_d = count_q + CW'(1);
            end
        end

        if (wb_wr && (wb_adr_i == ADR_RD_IDX)) begin
            rd_idx_d = wb_dat_i[DL-1:0];
        end

        if (wb_req && !wb_we_i) begin
            case (wb_adr_i)
                ADR_STATUS:  dat_d = status_w;
                ADR_COUNT:   dat_d = WB_DW'(count_q);
                ADR_RD_IDX:  dat_d = WB_DW'(rd_idx_q);
                ADR_DATA_LO: dat_d = data_ok ? ram_rdata[WB_DW-1:0] : '0;
                ADR_DATA_HI: begin
                    dat_d = data_ok ? WB_DW'(ram_rdata[TRACE_W-1:WB_DW]) : '0;
                    if (count_q != '0) begin
                        rd_idx_d = next_idx;
                    end
                end
                default:     dat_d = '0;
            endcase
        end

        // ARM/CLEAR restart capture and take priority over any trigger
        if (do_clear || do_arm) begin
            state_d     = do_clear ? ST_IDLE : ST_ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            wrapped_d   = 1'b0;
            rd_idx_d    = '0;
            post_cnt_d  = '0;
            trig_stop_d = 1'b0;
            ram_we      = 1'b0;
            wr_ptr_d    = '0;
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            rd_idx_q    <= '0;
            post_cnt_q  <= '0;
            trig_stop_q <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            rd_idx_q    <= rd_idx_d;
            post_cnt_q  <= post_cnt_d;
            trig_stop_q <= trig_stop_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            done_q      <= done_d;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign done_o   = done_q;

endmodule
